// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. Operands are latched on an accepted start
//   and consumed DIGIT bits per clock through a ripple of full-adder cells,
//   with the inter-digit carry held in a register. K = WIDTH/DIGIT cycles
//   after the start edge the result is copied into s/cout and done pulses.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN (adds the ovf port and the
//   signed-overflow register).
//
//   Ports
//     clk    in   rising-edge clock
//     rst    in   synchronous active-high reset
//     start  in   request, accepted when not running
//     sub    in   0: a + b + cin, 1: a - b
//     a, b   in   WIDTH-bit operands, sampled on accepted start
//     cin    in   carry-in (ignored for subtract)
//     busy   out  high while an operation is in flight
//     done   out  one-cycle pulse when s/cout are updated
//     s      out  result, held until the next completion
//     cout   out  carry out of the MSB (subtract: 1 = no borrow)
//     ovf    out  signed overflow (SERIAL_ADDER_OVF_EN only)
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one digit step per clock, K steps total
//   DONE  | single-cycle result strobe; a start here is accepted
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    logic [DIGIT-1:0] dsum;
    logic             c_msb_in;
    logic             c_out;
    logic             c_rip;
    logic [WIDTH-1:0] acc_shift;

    // Digit slice: ripple of full-adder cells over the low DIGIT bits.
    always_comb begin
        dsum     = '0;
        c_msb_in = 1'b0;
        c_rip    = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i] = a_q[i] ^ b_q[i] ^ c_rip;
            if (i == DIGIT - 1) begin
                c_msb_in = c_rip;
            end
            c_rip = ((a_q[i] ^ b_q[i]) & c_rip) | (a_q[i] & b_q[i]);
        end
        c_out = c_rip;
    end

    // New digit enters at the top; after K steps digit 0 sits at bit 0.
    assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = c_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    s_d     = acc_shift;
                    cout_d  = c_out;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = c_out ^ c_msb_in;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    // Subtract as a + ~b + 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Carry into the MSB only feeds the overflow flag.
    logic unused_c_msb_in;
    assign unused_c_msb_in = c_msb_in;
`endif

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign cout = cout_q;

endmodule
